// File: rtl/dadd_serial.sv
// dadd_serial: digit-serial BCD add/subtract unit with MSP430-style flags.
// Processes one 4-bit BCD digit per MCLK over N active digits
// (N = 2 in byte mode, DIGITS otherwise). A start pulse in IDLE
// launches one operation and done pulses for one cycle when the
// result and flags are valid.
//
// Optional feature macro: DADD_SERIAL_SUB_EN
//   defined   -> sub=1 adds the nines' complement of src (decimal subtract)
//   undefined -> sub is ignored and no complement logic is built
//
// Parameters:
//   DIGITS  number of BCD digits, even and >= 2 (W = 4*DIGITS)
// Ports:
//   MCLK    clock, all state updates on the rising edge
//   reset   synchronous active-high reset
//   start   launch request, sampled only in IDLE
//   bw      1 = byte mode (digits 0-1 only), 0 = full width
//   sub     1 = decimal subtract (only with DADD_SERIAL_SUB_EN)
//   src     source operand (BCD), W bits
//   dst     destination operand (BCD), W bits
//   cin     carry in (subtract: 1 = no borrow)
//   busy    high while an operation is in progress
//   done    one-cycle pulse when result/flags are valid
//   result  BCD result, held until the next accepted start
//   cout    decimal carry out of the last active digit
//   vout    overflow flag, always 0
//   nout    sign: result[7] in byte mode, result[W-1] otherwise
//   zout    1 when all active result digits are 0
module dadd_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                MCLK,
  input  logic                reset,
  input  logic                start,
  input  logic                bw,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] src,
  input  logic [4*DIGITS-1:0] dst,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                vout,
  output logic                nout,
  output logic                zout
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned KW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_nxt;

  logic [W-1:0]   src_q;
  logic [W-1:0]   dst_q;
  logic           c_q;
  logic           bw_q;
  logic [KW-1:0]  k_q;
  logic           nz_q;

  logic           load_c;
  logic           step_c;
  logic           fin_c;
  logic           last_c;

  logic [3:0]     s_eff;
  logic [4:0]     sum_c;
  logic           carry_c;
  logic [3:0]     digit_c;

`ifdef DADD_SERIAL_SUB_EN
  logic           sub_q;
`else
  logic           unused_sub;
  assign unused_sub = sub;
`endif

  // Last active digit: index 1 in byte mode, DIGITS-1 otherwise
  assign last_c = (k_q == (bw_q ? KW'(1) : KW'(DIGITS - 1)));

  // State register
  always_ff @(posedge MCLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode for the datapath
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fin_c  = 1'b0;
    unique case (state_q)
      IDLE:    load_c = start;
      RUN: begin
        step_c = 1'b1;
        fin_c  = last_c;
      end
      default: ;
    endcase
  end

  // One BCD digit: complement (optional), binary add, decimal correct
  always_comb begin
    s_eff = src_q[3:0];
`ifdef DADD_SERIAL_SUB_EN
    if (sub_q) s_eff = 4'(4'd9 - src_q[3:0]);
`endif
    sum_c   = 5'(dst_q[3:0]) + 5'(s_eff) + 5'(c_q);
    carry_c = (sum_c >= 5'd10);
    digit_c = carry_c ? 4'(sum_c + 5'd6) : sum_c[3:0];
  end

  // Datapath and registered outputs; operands shift right so digit k is
  // always in the low nibble
  always_ff @(posedge MCLK) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      c_q    <= 1'b0;
      bw_q   <= 1'b0;
      k_q    <= '0;
      nz_q   <= 1'b0;
`ifdef DADD_SERIAL_SUB_EN
      sub_q  <= 1'b0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      vout   <= 1'b0;
      nout   <= 1'b0;
      zout   <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      vout <= 1'b0;
      if (load_c) begin
        src_q  <= src;
        dst_q  <= dst;
        c_q    <= cin;
        bw_q   <= bw;
        k_q    <= '0;
        nz_q   <= 1'b0;
`ifdef DADD_SERIAL_SUB_EN
        sub_q  <= sub;
`endif
        result <= '0;
      end else if (step_c) begin
        src_q <= src_q >> 4;
        dst_q <= dst_q >> 4;
        c_q   <= carry_c;
        k_q   <= k_q + KW'(1);
        nz_q  <= nz_q | (digit_c != 4'd0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (k_q == KW'(i)) result[4*i +: 4] <= digit_c;
        end
        if (fin_c) begin
          cout <= carry_c;
          nout <= digit_c[3];
          zout <= ~(nz_q | (digit_c != 4'd0));
        end
      end
    end
  end

endmodule

// File: tb/tb_dadd_serial.sv
// tb_dadd_serial: self-checking bench for dadd_serial. Two instances
// (DIGITS=4 and DIGITS=8) share clock and reset. Expected values come
// from a decimal-arithmetic model; one compare process checks every
// done pulse against a queue of expectations.
module tb_dadd_serial;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic reset;

  logic        start_a, bw_a, sub_a, cin_a;
  logic [15:0] src_a, dst_a, result_a;
  logic        busy_a, done_a, cout_a, vout_a, nout_a, zout_a;

  logic        start_b, bw_b, sub_b, cin_b;
  logic [31:0] src_b, dst_b, result_b;
  logic        busy_b, done_b, cout_b, vout_b, nout_b, zout_b;

  dadd_serial #(.DIGITS(4)) u_a (
    .MCLK(MCLK), .reset(reset), .start(start_a), .bw(bw_a), .sub(sub_a),
    .src(src_a), .dst(dst_a), .cin(cin_a), .busy(busy_a), .done(done_a),
    .result(result_a), .cout(cout_a), .vout(vout_a), .nout(nout_a), .zout(zout_a)
  );

  dadd_serial #(.DIGITS(8)) u_b (
    .MCLK(MCLK), .reset(reset), .start(start_b), .bw(bw_b), .sub(sub_b),
    .src(src_b), .dst(dst_b), .cin(cin_b), .busy(busy_b), .done(done_b),
    .result(result_b), .cout(cout_b), .vout(vout_b), .nout(nout_b), .zout(zout_b)
  );

  typedef struct {
    int unsigned n;
    logic [31:0] res;
    bit          c;
    bit          neg;
    bit          z;
    int unsigned e0;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned done_t_a[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- decimal model ----------------
  function automatic longint unsigned bcd2dec(input logic [31:0] v, input int unsigned n);
    longint unsigned acc;
    acc = 0;
    for (int i = int'(n) - 1; i >= 0; i--) acc = acc * 10 + 64'(v[4*i +: 4]);
    return acc;
  endfunction

  function automatic logic [31:0] dec2bcd(input longint unsigned x, input int unsigned n);
    logic [31:0]     r;
    longint unsigned v;
    r = '0;
    v = x;
    for (int i = 0; i < int'(n); i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model(input int unsigned n, input logic [31:0] s, input logic [31:0] d,
                                input bit c, input bit sb, output logic [31:0] r, output bit co);
    longint unsigned pw, sv, tot;
    pw = 1;
    for (int i = 0; i < int'(n); i++) pw = pw * 10;
    sv = bcd2dec(s, n);
    if (sb) sv = pw - 1 - sv;
    tot = bcd2dec(d, n) + sv + 64'(c);
    co  = (tot >= pw);
    r   = dec2bcd(tot % pw, n);
  endfunction

  function automatic bit sub_eff(input bit sb);
`ifdef DADD_SERIAL_SUB_EN
    return sb;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk(input int unsigned n, input logic [31:0] s, input logic [31:0] d,
                              input bit c, input bit sb, input int unsigned e0);
    exp_t e;
    e.n  = n;
    e.e0 = e0;
    model(n, s, d, c, sub_eff(sb), e.res, e.c);
    e.neg = e.res[4*n-1];
    e.z   = (e.res == 32'd0);
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge MCLK) begin
    exp_t e;
    if (done_a) begin
      done_t_a.push_back(cyc);
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        e = q_a.pop_front();
        chk("a_result",  32'(result_a), e.res);
        chk("a_cout",    32'(cout_a),   32'(e.c));
        chk("a_vout",    32'(vout_a),   32'd0);
        chk("a_nout",    32'(nout_a),   32'(e.neg));
        chk("a_zout",    32'(zout_a),   32'(e.z));
        chk("a_busy_dn", 32'(busy_a),   32'd0);
        chk("a_latency", cyc + 1 - e.e0, e.n + 1);
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        e = q_b.pop_front();
        chk("b_result",  result_b,      e.res);
        chk("b_cout",    32'(cout_b),   32'(e.c));
        chk("b_vout",    32'(vout_b),   32'd0);
        chk("b_nout",    32'(nout_b),   32'(e.neg));
        chk("b_zout",    32'(zout_b),   32'(e.z));
        chk("b_busy_dn", 32'(busy_b),   32'd0);
        chk("b_latency", cyc + 1 - e.e0, e.n + 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic scramble_a();
    src_a = 16'($urandom); dst_a = 16'($urandom);
    cin_a = 1'($urandom);  bw_a  = 1'($urandom); sub_a = 1'($urandom);
  endtask

  task automatic launch_a(input bit b, input bit sb, input logic [15:0] s,
                          input logic [15:0] d, input bit c);
    bw_a = b; sub_a = sb; src_a = s; dst_a = d; cin_a = c; start_a = 1'b1;
    q_a.push_back(mk(b ? 32'd2 : 32'd4, 32'(s), 32'(d), c, sb, cyc + 1));
    @(negedge MCLK);
    start_a = 1'b0;
    scramble_a();
  endtask

  task automatic launch_b(input bit b, input logic [31:0] s, input logic [31:0] d, input bit c);
    bw_b = b; sub_b = 1'b0; src_b = s; dst_b = d; cin_b = c; start_b = 1'b1;
    q_b.push_back(mk(b ? 32'd2 : 32'd8, s, d, c, 1'b0, cyc + 1));
    @(negedge MCLK);
    start_b = 1'b0;
    src_b = $urandom; dst_b = $urandom; cin_b = 1'($urandom);
  endtask

  // Bounded wait until all expected done pulses have arrived, then one
  // more cycle so the DUT is back in IDLE
  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge MCLK);
      if (q_a.size() == 0 && q_b.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d/%0d pending, want 0", q_a.size(), q_b.size());
      q_a.delete(); q_b.delete();
    end
    @(negedge MCLK);
  endtask

  task automatic pin(input string name, input int unsigned n, input logic [31:0] s,
                     input logic [31:0] d, input bit c, input bit sb,
                     input logic [31:0] r_want, input bit c_want);
    logic [31:0] r;
    bit          co;
    model(n, s, d, c, sb, r, co);
    chk({name, "_res"}, r, r_want);
    chk({name, "_c"},   32'(co), 32'(c_want));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] t0;
    int          dn0;

    reset = 1'b1;
    start_a = 1'b0; bw_a = 1'b0; sub_a = 1'b0; cin_a = 1'b0; src_a = '0; dst_a = '0;
    start_b = 1'b0; bw_b = 1'b0; sub_b = 1'b0; cin_b = 1'b0; src_b = '0; dst_b = '0;

    // Hand-computed values pin the model
    pin("m_add",  4, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'h6912, 1'b0);
    pin("m_wrap", 4, 32'h9999, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1);
    pin("m_neg",  4, 32'h7999, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0);
    pin("m_byte", 2, 32'h4599, 32'h7701, 1'b0, 1'b0, 32'h0000, 1'b1);
    pin("m_sub1", 4, 32'h0123, 32'h0321, 1'b1, 1'b1, 32'h0198, 1'b1);
    pin("m_sub2", 4, 32'h0321, 32'h0123, 1'b1, 1'b1, 32'h9802, 1'b0);
    pin("m_d8",   8, 32'h00000001, 32'h99999999, 1'b0, 1'b0, 32'h00000000, 1'b1);

    repeat (2) @(negedge MCLK);
    chk("rst_busy",   32'(busy_a),   32'd0);
    chk("rst_done",   32'(done_a),   32'd0);
    chk("rst_result", 32'(result_a), 32'd0);
    chk("rst_flags",  32'({cout_a, vout_a, nout_a, zout_a}), 32'd0);
    reset = 1'b0;
    @(negedge MCLK);

    // Basic word add; result held after done
    launch_a(1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0);
    chk("a_busy_run", 32'(busy_a), 32'd1);
    wait_idle(20);
    chk("a_hold", 32'(result_a), 32'h6912);
    chk("a_idle_busy", 32'(busy_a), 32'd0);

    launch_a(1'b0, 1'b0, 16'h9999, 16'h0000, 1'b1);  wait_idle(20);
    launch_a(1'b0, 1'b0, 16'h7999, 16'h0001, 1'b0);  wait_idle(20);
    launch_a(1'b1, 1'b0, 16'h4599, 16'h7701, 1'b0);  wait_idle(20);
    launch_a(1'b1, 1'b0, 16'h3350, 16'h1240, 1'b0);  wait_idle(20);
    launch_a(1'b0, 1'b1, 16'h0123, 16'h0321, 1'b1);  wait_idle(20);
    launch_a(1'b0, 1'b1, 16'h0321, 16'h0123, 1'b1);  wait_idle(20);
    launch_a(1'b1, 1'b1, 16'h0012, 16'h0005, 1'b1);  wait_idle(20);

    // start held for 12 edges: two operations, operands swapped between
    done_t_a.delete();
    dn0 = 0;
    bw_a = 1'b0; sub_a = 1'b0; src_a = 16'h2468; dst_a = 16'h1357; cin_a = 1'b0;
    start_a = 1'b1;
    q_a.push_back(mk(32'd4, 32'h2468, 32'h1357, 1'b0, 1'b0, cyc + 1));
    @(negedge MCLK);
    scramble_a();
    repeat (5) @(negedge MCLK);
    bw_a = 1'b0; sub_a = 1'b0; src_a = 16'h0999; dst_a = 16'h9001; cin_a = 1'b1;
    q_a.push_back(mk(32'd4, 32'h0999, 32'h9001, 1'b1, 1'b0, cyc + 1));
    @(negedge MCLK);
    scramble_a();
    repeat (5) @(negedge MCLK);
    start_a = 1'b0;
    wait_idle(20);
    repeat (6) @(negedge MCLK);
    chk("cont_pulses", 32'(done_t_a.size()), 32'd2);
    if (done_t_a.size() == 2) chk("cont_gap", done_t_a[1] - done_t_a[0], 32'd6);
    else dn0 = 1;
    if (dn0 != 0) chk("cont_gap_missing", 32'(done_t_a.size()), 32'd2);

    // Reset sampled at the third RUN edge aborts the operation
    bw_a = 1'b0; sub_a = 1'b0; src_a = 16'h5555; dst_a = 16'h4444; cin_a = 1'b1;
    start_a = 1'b1;
    @(negedge MCLK);            // after E0
    start_a = 1'b0;
    @(negedge MCLK);            // after E1
    @(negedge MCLK);            // after E2
    reset = 1'b1;
    @(negedge MCLK);            // after E3
    reset = 1'b0;
    chk("abort_busy",   32'(busy_a),   32'd0);
    chk("abort_done",   32'(done_a),   32'd0);
    chk("abort_result", 32'(result_a), 32'd0);
    chk("abort_flags",  32'({cout_a, vout_a, nout_a, zout_a}), 32'd0);
    repeat (8) @(negedge MCLK);
    chk("abort_no_done", 32'(q_a.size()), 32'd0);

    // Eight-digit instance
    launch_b(1'b0, 32'h00000001, 32'h99999999, 1'b0);  wait_idle(30);
    t0 = result_b;
    chk("b_hold", t0, 32'h00000000);
    launch_b(1'b0, 32'h49999999, 32'h50000000, 1'b0);  wait_idle(30);
    launch_b(1'b1, 32'h12345678, 32'h87654321, 1'b1);  wait_idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
